oam_dma_controller: RTL and testbench
=====================================

# oam_dma_controller

Sequencer for the NES sprite DMA ($4014). A CPU write to $4014 halts the CPU and takes the 2 KB internal RAM read port plus the CPU bus address. The block copies the 256 bytes of page $XX00–$XXFF into PPU OAM using alternating get/put cycles, then returns bus ownership to the CPU. It sits between the CPU core, the CPU RAM/bus address mux, and the PPU OAM write port.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.

Ports:
- clk  in  1  system clock; one rising edge = one CPU cycle.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  16  CPU bus address, snooped.
- cpu_wr  in  1  CPU write strobe, snooped.
- cpu_wdata  in  8  CPU write data; source page number when the trigger address is written.
- cpu_stall  out  1  CPU halt request; the CPU holds its state while this is 1.
- bus_owner  out  1  1 = DMA drives the bus address and RAM address; RAM write_enable is forced 0 by the mux.
- dma_addr  out  16  source read address: {page, count}.
- dma_rd  out  1  read strobe during GET cycles.
- rd_data  in  8  source data. It has registered-read latency: valid in the cycle after dma_rd.
- oam_we  out  1  OAM write strobe during PUT cycles.
- oam_addr  out  8  OAM byte index.
- oam_wdata  out  8  OAM write data; equals rd_data when oam_we = 1, otherwise 0.

## Operation
- Parity flop `odd`: 0 in the first cycle after reset release, toggles every clk.
- Trigger: cpu_wr = 1 and cpu_addr = DMA_REG_ADDR at a rising edge while in IDLE. On that edge the block latches page = cpu_wdata, clears count to 0 and enters HALT.
- Trigger writes seen in any state other than IDLE are ignored. Writes to any other address never trigger.
- State machine:
  - IDLE → HALT on trigger.
  - HALT → GET if odd = 1 during HALT; HALT → ALIGN if odd = 0.
  - ALIGN → GET.
  - GET → PUT.
  - PUT → GET if count ≠ 8'hFF. PUT → IDLE if count = 8'hFF.
  - Count increments on the edge ending PUT. It wraps 8'hFF → 8'h00, and the page is never incremented.
- GET cycles always have odd = 0. PUT cycles always have odd = 1.
- Outputs by state:
  - cpu_stall = bus_owner = (state ≠ IDLE).
  - dma_rd = 1 in GET only.
  - dma_addr = {page, count} in all non-IDLE states, 16'h0000 in IDLE.
  - oam_we = 1 in PUT only.
  - oam_addr = count.
- The source may be any page. The top level routes rd_data from internal RAM for pages $00–$1F (address[10:0], mirrored). Other pages are routed from their devices.

## Timing
- Reset (async, immediate): state IDLE, page 0, count 0, odd 0. Outputs: cpu_stall 0, bus_owner 0, dma_rd 0, dma_addr 0, oam_we 0, oam_addr 0, oam_wdata 0.
- Reset mid-transfer aborts with no further OAM writes; bytes already written stay written.
- Trigger in cycle W: cpu_stall rises in cycle W+1 (HALT), registered from state.
- Trigger cycle W with odd = 0: 513 stall cycles (HALT + 256×(GET, PUT)).
- Trigger cycle W with odd = 1: 514 stall cycles (HALT + ALIGN + 256×(GET, PUT)).
- Byte k: GET in some cycle G with dma_addr = {page, k}. PUT in cycle G+1 with oam_addr = k and oam_wdata = rd_data.
- Return to IDLE on the edge ending the final PUT. cpu_stall and bus_owner are 0 in the next cycle.
- A new trigger is accepted in that next cycle or later.
- The 256 oam_we pulses are never adjacent; every PUT is preceded by its own GET.

## Test plan
- Even trigger:
  - Stimulus: preload RAM $0200+i = i^8'h5A; write $02 to $4014 in an odd = 0 cycle.
  - Response: cpu_stall high for exactly 513 cycles; 256 oam_we pulses; OAM[i] = i^8'h5A; first dma_addr = 16'h0200, last 16'h02FF.
- Odd trigger: same stimulus with the write in an odd = 1 cycle → cpu_stall high for exactly 514 cycles; one ALIGN cycle before the first GET; every GET has odd = 0.
- Page wrap: write $07 → reads $0700..$07FF, no read at $0800; count wraps to 0 and the block reaches IDLE.
- Non-trigger and busy writes:
  - Writes to $4015 and $2004 → no state change.
  - A $4014 write during the active DMA (forced) → ignored; page stays at its original value; still 256 PUTs.
- Reset mid-operation: assert rst during byte 100's PUT → all outputs 0 immediately, state IDLE; a fresh $4014 write afterwards completes a full 513/514-cycle transfer correctly.
- Back-to-back: trigger a second DMA in the first IDLE cycle after completion → accepted; total behaviour matches two independent transfers.

Source files
------------

// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer: on a write to DMA_REG_ADDR, halts the CPU and copies
// 256 bytes of page {page, 00..FF} into PPU OAM using alternating GET/PUT cycles.
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_stall,
    output logic        bus_owner,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  rd_data,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_GET,
        S_PUT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  count_q, count_d;
    logic        odd_q;
    logic        stall_q, rd_q, we_q;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_wr && cpu_addr == DMA_REG_ADDR) begin
                    state_d = S_HALT;
                    page_d  = cpu_wdata;
                    count_d = 8'h00;
                end
            end
            // GET must land on an even cycle; an odd-parity HALT lines that up.
            S_HALT:  state_d = odd_q ? S_GET : S_ALIGN;
            S_ALIGN: state_d = S_GET;
            S_GET:   state_d = S_PUT;
            S_PUT: begin
                count_d = count_q + 8'd1;
                state_d = (count_q == 8'hFF) ? S_IDLE : S_GET;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change with the state flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            count_q <= 8'h00;
            odd_q   <= 1'b0;
            stall_q <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            count_q <= count_d;
            odd_q   <= ~odd_q;
            stall_q <= (state_d != S_IDLE);
            rd_q    <= (state_d == S_GET);
            we_q    <= (state_d == S_PUT);
        end
    end

    assign cpu_stall = stall_q;
    assign bus_owner = stall_q;
    assign dma_rd    = rd_q;
    assign dma_addr  = stall_q ? {page_q, count_q} : 16'h0000;
    assign oam_we    = we_q;
    assign oam_addr  = count_q;
    assign oam_wdata = we_q ? rd_data : 8'h00;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomized bench for oam_dma_controller against a transfer-level reference model.
module tb_oam_dma_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic        cpu_stall, bus_owner, dma_rd, oam_we;
    logic [15:0] dma_addr;
    logic [7:0]  rd_data, oam_addr, oam_wdata;

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc   = 0;

    logic [7:0] ram     [2048];
    logic [7:0] oam_mem [256];

    oam_dma_controller #(.DMA_REG_ADDR(16'h4014)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .bus_owner(bus_owner),
        .dma_addr(dma_addr), .dma_rd(dma_rd), .rd_data(rd_data),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata)
    );

    always #5 clk = ~clk;

    // Source bus contents: internal RAM mirrored below $2000, a fixed pattern elsewhere.
    function automatic logic [7:0] src(input logic [15:0] a);
        if (a[15:8] < 8'h20) return ram[a[10:0]];
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    // Cycle index since reset release; its LSB is the expected CPU cycle parity.
    always @(posedge clk) ncyc <= rst ? 0 : ncyc + 1;

    // Registered-read source; junk when not reading so ungated data shows up.
    always @(posedge clk) rd_data <= dma_rd ? src(dma_addr) : 8'($urandom);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_dma(input logic [7:0] pg, input bit want_odd, input bit imm,
                          input bit busy, input int abort_at);
        int stall_n = 0, gets = 0, puts = 0, first_get = -1;
        int addr_err = 0, data_err = 0, par_err = 0, adj_err = 0;
        int own_err = 0, wd0_err = 0, page_err = 0, mism = 0, bad = 0;
        bit prev_rd = 0, done = 0, trig_odd;
        for (int i = 0; i < 256; i++) oam_mem[i] = 'x;
        if (!imm) begin
            @(posedge clk); #1;
            if (ncyc[0] != want_odd) begin @(posedge clk); #1; end
        end
        trig_odd  = ncyc[0];
        cpu_addr  = 16'h4014;
        cpu_wdata = pg;
        cpu_wr    = 1'b1;
        @(posedge clk); #1;
        cpu_wr    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        for (int k = 0; k < 700 && !done; k++) begin
            @(negedge clk);
            if (bus_owner !== cpu_stall) own_err++;
            if (!oam_we && oam_wdata !== 8'h00) wd0_err++;
            if (!cpu_stall) begin
                done = 1;
                chk("idle_addr", 32'(dma_addr), 32'h0);
            end else begin
                stall_n++;
                if (dma_addr[15:8] !== pg) page_err++;
                if (dma_rd) begin
                    if (first_get < 0) first_get = k;
                    if (dma_addr !== {pg, gets[7:0]}) addr_err++;
                    if (ncyc[0] !== 1'b0) par_err++;
                    gets++;
                end
                if (oam_we) begin
                    if (!prev_rd) adj_err++;
                    if (ncyc[0] !== 1'b1) par_err++;
                    if (oam_addr !== puts[7:0]) addr_err++;
                    if (oam_wdata !== src({pg, puts[7:0]})) data_err++;
                    oam_mem[oam_addr] = oam_wdata;
                    puts++;
                    if (abort_at >= 0 && puts == abort_at + 1) begin
                        rst = 1'b1;
                        #1;
                        chk("rst_flags", 32'({cpu_stall, bus_owner, dma_rd, oam_we}), 32'h0);
                        chk("rst_daddr", 32'(dma_addr), 32'h0);
                        chk("rst_oam", 32'({oam_addr, oam_wdata}), 32'h0);
                        chk("abort_puts", puts, abort_at + 1);
                        chk("abort_data", data_err + addr_err, 0);
                        repeat (2) @(negedge clk);
                        rst = 1'b0;
                        repeat (12) begin
                            @(negedge clk);
                            if (oam_we || cpu_stall) bad++;
                        end
                        chk("abort_quiet", bad, 0);
                        return;
                    end
                end
                prev_rd = dma_rd;
                if (busy && k == 60) begin cpu_addr = 16'h4014; cpu_wdata = ~pg; cpu_wr = 1'b1; end
                if (busy && k == 61) begin cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_wr = 1'b0; end
            end
        end
        for (int i = 0; i < 256; i++)
            if (oam_mem[i] !== src({pg, 8'(i)})) mism++;
        chk("done", 32'(done), 32'h1);
        chk("stall_cyc", stall_n, trig_odd ? 514 : 513);
        chk("first_get", first_get, trig_odd ? 2 : 1);
        chk("gets", gets, 256);
        chk("puts", puts, 256);
        chk("addr_err", addr_err, 0);
        chk("data_err", data_err, 0);
        chk("par_err", par_err, 0);
        chk("adj_err", adj_err, 0);
        chk("own_err", own_err, 0);
        chk("wd0_err", wd0_err, 0);
        chk("page_err", page_err, 0);
        chk("oam", mism, 0);
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_wr    = 1'b0;
        cpu_wdata = 8'h00;
        for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[11'h200 + 11'(i)] = 8'(i) ^ 8'h5A;
        #1;
        chk("rst0_flags", 32'({cpu_stall, bus_owner, dma_rd, oam_we}), 32'h0);
        chk("rst0_daddr", 32'(dma_addr), 32'h0);
        chk("rst0_oam", 32'({oam_addr, oam_wdata}), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Writes to other registers, and a read of the trigger address, must not start a transfer.
        bad = 0;
        @(posedge clk); #1;
        cpu_addr = 16'h4015; cpu_wdata = 8'h02; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_addr = 16'h2004;
        @(posedge clk); #1;
        cpu_addr = 16'h4014; cpu_wr = 1'b0;
        @(posedge clk); #1;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        repeat (4) begin
            @(negedge clk);
            if (cpu_stall || bus_owner || dma_rd || oam_we || dma_addr != 16'h0) bad++;
        end
        chk("notrig", bad, 0);

        do_dma(8'h02, 1'b0, 1'b0, 1'b0, -1);
        do_dma(8'h02, 1'b1, 1'b0, 1'b0, -1);
        do_dma(8'h07, 1'b0, 1'b0, 1'b0, -1);
        do_dma(8'h1A, 1'b1, 1'b0, 1'b1, -1);
        do_dma(8'h02, 1'b0, 1'b0, 1'b0, 100);
        do_dma(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
        do_dma(8'h03, 1'b1, 1'b0, 1'b0, -1);
        do_dma(8'h85, 1'b0, 1'b1, 1'b0, -1);
        repeat (3) do_dma(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
